// File: rtl/register_write_queue.sv
// Write-back queue feeding register file port 3: FIFO of (selector, value), one retire per clock, forwarding lookups.
// Define REG_WRITE_QUEUE_BYPASS_EN to let a request skip the empty FIFO straight into the output stage.
module register_write_queue #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_selector,
  input  logic [31:0]      in_value,
  input  logic             hold,
  output logic             write_enable_3,
  output logic [4:0]       selector_3,
  output logic [31:0]      value_3,
  input  logic [4:0]       lookup_selector_1,
  input  logic [4:0]       lookup_selector_2,
  output logic             lookup_hit_1,
  output logic             lookup_hit_2,
  output logic [31:0]      lookup_value_1,
  output logic [31:0]      lookup_value_2,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [4:0]       sel_mem_q [DEPTH];
  logic [31:0]      val_mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             we_q, we_d;
  logic [4:0]       sel_q, sel_d;
  logic [31:0]      val_q, val_d;
  logic             push, enq, pop, bypass;

  assign full           = (count_q == (PTR_W+1)'(DEPTH));
  assign empty          = (count_q == '0);
  assign in_ready       = !full;
  assign count          = count_q;
  assign write_enable_3 = we_q;
  assign selector_3     = sel_q;
  assign value_3        = val_q;

  assign push = in_valid && in_ready;
  assign pop  = !empty && !hold;
`ifdef REG_WRITE_QUEUE_BYPASS_EN
  assign bypass = empty && !hold && in_valid && (in_selector != 5'd0);
`else
  assign bypass = 1'b0;
`endif
  // Writes to $0 are accepted but dropped since that register is hard-wired.
  assign enq = push && (in_selector != 5'd0) && !bypass;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    we_d     = 1'b0;
    sel_d    = sel_q;
    val_d    = val_q;
    if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      we_d     = 1'b1;
      sel_d    = sel_mem_q[rd_ptr_q];
      val_d    = val_mem_q[rd_ptr_q];
    end else if (bypass) begin
      we_d  = 1'b1;
      sel_d = in_selector;
      val_d = in_value;
    end
    case ({enq, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      val_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      val_q    <= val_d;
    end
  end

  // Storage needs no reset: entries outside [rd_ptr, rd_ptr+count) are never observed.
  always_ff @(posedge clock) begin
    if (enq) begin
      sel_mem_q[wr_ptr_q] <= in_selector;
      val_mem_q[wr_ptr_q] <= in_value;
    end
  end

  // Scan oldest to newest so the youngest match overwrites older ones.
  function automatic logic [32:0] lookup(input logic [4:0] s);
    logic [32:0]      r;
    logic [PTR_W-1:0] idx;
    r = '0;
    if (s != 5'd0) begin
      if (we_q && (sel_q == s)) r = {1'b1, val_q};
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_q + PTR_W'(i);
        if (((PTR_W+1)'(i) < count_q) && (sel_mem_q[idx] == s)) r = {1'b1, val_mem_q[idx]};
      end
    end
    return r;
  endfunction

  always_comb begin
    {lookup_hit_1, lookup_value_1} = lookup(lookup_selector_1);
    {lookup_hit_2, lookup_value_2} = lookup(lookup_selector_2);
  end

endmodule

// File: doc/register_write_queue.md
Name: register_write_queue

Overview:
- Writer side of the register file's third (write) port; drives write_enable_3 / selector_3 / value_3 of register_file.
- Buffers register write-back requests in a small FIFO and retires one per clock, with hold control from the pipeline.
- Provides forwarding lookups so decode can read values that are still queued or staged and not yet committed.

Parameters:
- DEPTH, 4, FIFO entry count; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  write request present.
- in_ready  output  1  queue can accept; equals !full.
- in_selector  input  5  destination register number.
- in_value  input  32  data to write.
- hold  input  1  when high, no entry is popped this cycle.
- write_enable_3  output  1  register file write strobe (registered).
- selector_3  output  5  register file write address (registered).
- value_3  output  32  register file write data (registered).
- lookup_selector_1  input  5  forwarding query 1.
- lookup_selector_2  input  5  forwarding query 2.
- lookup_hit_1  output  1  query 1 matches a pending write.
- lookup_hit_2  output  1  query 2 matches a pending write.
- lookup_value_1  output  32  newest pending value for query 1.
- lookup_value_2  output  32  newest pending value for query 2.
- count  output  PTR_W+1  number of queued entries, excluding the output stage.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (async, any time): write_enable_3=0, selector_3=0, value_3=0, count=0, pointers=0, empty=1, full=0, in_ready=1.
- Reset mid-operation: all queued and staged writes are discarded with no write strobe.
- Push: occurs on an edge where in_valid && in_ready.
  - in_selector==0: the request is accepted and discarded; it is not enqueued, because $0 is hard-wired.
- Pop: occurs on an edge where !empty && !hold.
  - The head entry is loaded into the output stage (selector_3, value_3) and write_enable_3 is set to 1.
  - Without a pop, write_enable_3 is 0 on the next cycle; selector_3 and value_3 hold their last values.
- Latency (feature off): a request accepted at edge k into an empty queue is popped at edge k+1. write_enable_3 is high for the cycle after edge k+1, and register_file commits at edge k+2.
- Throughput: one retire per cycle while !hold.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - A push and pop on an empty queue is impossible; the pushed entry pops on the next edge.
- Full: in_ready=0, so requests are back-pressured. in_ready derives from registered count only; a pop in the same cycle does not raise it.
- Wrap-around: pointers increment modulo DEPTH; full/empty come from count, not pointer compare.
- hold=1: pop is suppressed, pushes still accepted up to DEPTH, write_enable_3 drops to 0 on the next cycle.
- Ordering: entries retire strictly FIFO; duplicate selectors are all written, in order.
- Forwarding (combinational):
  - Searches the output stage (while write_enable_3=1) and all valid queue entries.
  - On multiple matches, the newest wins: the youngest queued entry, then the output stage.
  - Lookup of register 0 always gives hit=0, value=0.
  - No match gives hit=0, value=0.
  - The in_* request of the current cycle is not searched.

Optional Feature:
- Macro: REG_WRITE_QUEUE_BYPASS_EN.
- Defined: on an edge with empty && !hold && in_valid && in_selector!=0, the request goes straight to the output stage and is not enqueued. write_enable_3 is high the cycle after acceptance, giving 1-cycle latency. count stays 0.
- Undefined: every request passes through the FIFO, with the 2-edge latency above.

Test Plan:
- Reset, then push (sel=1, val=10) at edge 1 with hold=0 -> write_enable_3=1, selector_3=1, value_3=10 after edge 2 for exactly one cycle; empty=1 after edge 2.
- hold=1, push sel=2..5 with values 20,30,40,50 -> full=1 and in_ready=0 after the 4th push; a 5th request is not accepted. Release hold -> four consecutive strobes with sel 2,3,4,5 and values 20,30,40,50.
- Push sel=0 val=99 -> in_ready=1, count stays 0, write_enable_3 never asserts.
- hold=1, queue (7,70) then (7,71); lookup_selector_1=7 -> hit_1=1, value_1=71. lookup_selector_2=8 -> hit_2=0, value_2=0.
- Continuous push every cycle with hold toggling 1/0 across 10 pointer wraps -> retired sequence equals pushed sequence; count never exceeds 4.
- Assert reset while 3 entries are queued and write_enable_3=1 -> all outputs return to reset values immediately (asynchronously); no further strobes occur after reset is released.
